// File: rtl/picomips_pkg.sv
// Shared types for the picoMIPS fetch/execute controller: opcode classes,
// sequencer states and the bundle of per-cycle control strobes.
package picomips_pkg;

  typedef enum logic [2:0] {
    OP_ALU,
    OP_LDI,
    OP_BEQ,
    OP_BNE,
    OP_JMP,
    OP_IN,
    OP_OUT,
    OP_HLT
  } op_class_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_WAIT_IN,
    S_WAIT_OUT,
    S_HALT
  } seq_state_t;

  // One cycle's worth of sequencer outputs, decoded together so the reset
  // gating and the retire detection operate on a single value.
  typedef struct packed {
    logic ir_load;
    logic reg_we;
    logic in_ack;
    logic out_valid;
    logic pc_inc;
    logic pc_branch_abs;
    logic pc_branch_rel;
    logic halted;
  } seq_ctrl_t;

  localparam seq_ctrl_t CTRL_IDLE = '0;

  // An instruction retires in any cycle that moves the program counter.
  function automatic logic is_retire(input seq_ctrl_t c);
    return c.pc_inc | c.pc_branch_abs | c.pc_branch_rel;
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Saturating count of retired instructions; sticks at all-ones instead of
// wrapping so software can tell an overflowed count from a small one.
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute controller for picoMIPS. Mealy decode of state
// and inputs; SEQ_SINGLE_STEP_EN adds a stepReq gate on instruction fetch.
module pc_sequencer
  import picomips_pkg::*;
#(
  parameter int OP_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             stepReq,
`endif
  input  logic [OP_W-1:0]  opClass,
  input  logic             zero,
  input  logic             inValid,
  output logic             inAck,
  output logic             outValid,
  input  logic             outReady,
  output logic             irLoad,
  output logic             regWe,
  output logic             pcInc,
  output logic             pcBranchAbs,
  output logic             pcBranchRel,
  output logic             halted,
  output logic [CNT_W-1:0] instrCount
);

  seq_state_t state, state_nxt;
  seq_ctrl_t  ctrl, ctrl_q;
  op_class_t  op;

  assign op = op_class_t'(opClass);

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ctrl      = CTRL_IDLE;
    state_nxt = state;
    unique case (state)
      S_FETCH: begin
`ifdef SEQ_SINGLE_STEP_EN
        if (stepReq) begin
          ctrl.ir_load = 1'b1;
          state_nxt    = S_EXEC;
        end
`else
        ctrl.ir_load = 1'b1;
        state_nxt    = S_EXEC;
`endif
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        unique case (op)
          OP_ALU, OP_LDI: begin
            ctrl.reg_we = 1'b1;
            ctrl.pc_inc = 1'b1;
          end
          OP_BEQ: begin
            ctrl.pc_branch_rel = zero;
            ctrl.pc_inc        = ~zero;
          end
          OP_BNE: begin
            ctrl.pc_branch_rel = ~zero;
            ctrl.pc_inc        = zero;
          end
          OP_JMP: ctrl.pc_branch_abs = 1'b1;
          OP_IN:  state_nxt = S_WAIT_IN;
          OP_OUT: state_nxt = S_WAIT_OUT;
          OP_HLT: state_nxt = S_HALT;
          default: ;
        endcase
      end
      S_WAIT_IN: begin
        if (inValid) begin
          ctrl.reg_we = 1'b1;
          ctrl.in_ack = 1'b1;
          ctrl.pc_inc = 1'b1;
          state_nxt   = S_FETCH;
        end
      end
      S_WAIT_OUT: begin
        // outValid is held for the whole wait and drops once we leave.
        ctrl.out_valid = 1'b1;
        if (outReady) begin
          ctrl.pc_inc = 1'b1;
          state_nxt   = S_FETCH;
        end
      end
      S_HALT: ctrl.halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  // The reset cycle is silent: no fetch, no ack, no PC movement.
  assign ctrl_q = rst ? CTRL_IDLE : ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  assign irLoad      = ctrl_q.ir_load;
  assign regWe       = ctrl_q.reg_we;
  assign inAck       = ctrl_q.in_ack;
  assign outValid    = ctrl_q.out_valid;
  assign pcInc       = ctrl_q.pc_inc;
  assign pcBranchAbs = ctrl_q.pc_branch_abs;
  assign pcBranchRel = ctrl_q.pc_branch_rel;
  assign halted      = ctrl_q.halted;

  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (is_retire(ctrl_q)),
    .count(instrCount)
  );

  a_one_pc_strobe: assert property (@(posedge clk)
    $onehot0({pcInc, pcBranchAbs, pcBranchRel}));

  a_no_load_and_write: assert property (@(posedge clk)
    !(irLoad && regWe));

endmodule
